// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//
// Serial receive front-end for the wi23 UART. Deserializes the asynchronous
// RX pin (8 data bits, no parity, 1 stop bit, LSB first) into bytes and
// queues them in a small show-ahead FIFO for the register logic to read.
// Framing errors and overruns are reported through sticky flags.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per bit period (>= 4)
//   FIFO_DEPTH    receive FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   RX         in   asynchronous serial input, idles high
//   rd_en      in   pop the FIFO head (ignored while rx_valid = 0)
//   clr_err    in   clear frame_err and overrun
//   rx_data    out  FIFO head byte, 8'h00 when the FIFO is empty
//   rx_valid   out  FIFO holds at least one byte
//   frame_err  out  sticky: a stop bit was sampled low
//   overrun    out  sticky: a received byte was dropped on a full FIFO
//   busy       out  receiver FSM is not idle
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       rd_en,
  input  logic       clr_err,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  // -------------------------------------------------------------------------
  // Local constants
  // -------------------------------------------------------------------------
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Start bit is checked half a bit period in; every later sample is one
  // full bit period after the previous one, so all land mid-bit.
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_e;

  // -------------------------------------------------------------------------
  // Declarations
  // -------------------------------------------------------------------------
  logic             rx_meta_q, rx_meta_d;
  logic             rx_s_q, rx_s_d;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;

  logic             push_req;   // a complete, well-framed byte this cycle
  logic             frame_set;  // stop bit sampled low this cycle

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             fifo_full, fifo_empty;
  logic             do_push, do_pop, ovr_set;

  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;

  // -------------------------------------------------------------------------
  // Input synchronizer: two flops, both resetting to the idle (high) level so
  // that leaving reset never looks like a start bit.
  // -------------------------------------------------------------------------
  always_comb begin
    rx_meta_d = RX;
    rx_s_d    = rx_meta_q;
  end

  // -------------------------------------------------------------------------
  // FSM process 1: state and datapath registers
  // -------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM process 2: next state, bit timing and deserialization
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_set = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end

      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          // A line that is high again at mid-start-bit was only a glitch.
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) state_d = S_STOP;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end

      S_STOP: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          // Returning to IDLE at mid-stop-bit leaves half a bit of margin to
          // catch a back-to-back start edge.
          if (rx_s_q) begin
            push_req = 1'b1;
            state_d  = S_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = S_WAIT_HIGH;
          end
        end
      end

      S_WAIT_HIGH: begin
        // Hold off until the line idles so a break is never taken as a frame.
        cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM process 3: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    busy = (state_q != S_IDLE);
  end

  // -------------------------------------------------------------------------
  // Receive FIFO: circular buffer with a separate occupancy count so that
  // full and empty are unambiguous when the pointers are equal.
  // -------------------------------------------------------------------------
  always_comb begin
    fifo_full  = (count_q == DEPTH_C);
    fifo_empty = (count_q == '0);

    // A pop on an empty FIFO is ignored even if a push lands in the same
    // cycle; on a full FIFO a simultaneous pop frees the slot for the push.
    do_pop  = rd_en && !fifo_empty;
    do_push = push_req && (!fifo_full || do_pop);
    ovr_set = push_req && fifo_full && !do_pop;

    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; its contents are only visible
  // through count_q, which is reset, so resetting it would add logic for no
  // observable effect.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= shift_q;
  end

  always_comb begin
    rx_valid = !fifo_empty;
    rx_data  = fifo_empty ? 8'h00 : mem_q[rd_ptr_q];
  end

  // -------------------------------------------------------------------------
  // Sticky status: a new error event wins over a simultaneous clear so that
  // no event is ever lost.
  // -------------------------------------------------------------------------
  always_comb begin
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;
    if (clr_err) begin
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end
    if (frame_set) frame_err_d = 1'b1;
    if (ovr_set)   overrun_d   = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//
// Directed bench for uart_rx with CLKS_PER_BIT = 8 and FIFO_DEPTH = 4.
// Frames are driven cycle by cycle; DUT outputs are captured 1 ns after
// every rising edge into per-frame logs indexed by the edge count since the
// frame began, so timing points can be checked after the frame completes.
//
// Edge arithmetic for one frame whose start bit is driven just after edge 0:
//   edge 2  synchronized line goes low (busy still 0)
//   edge 3  START entered, busy = 1
//   edge 7  start-bit sample
//   edge 79 stop-bit sample: push / frame_err, FSM back in IDLE
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int CPB        = 8;
  localparam int DEPTH      = 4;
  localparam int PUSH_EDGE  = 3 + CPB / 2 + 9 * CPB;  // 79
  localparam int FRAME_CYC  = 10 * CPB;               // 80
  localparam int LOG_LEN    = 256;

  logic       clk;
  logic       rst;
  logic       RX;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int ecnt     = 0;

  logic       obs_valid [LOG_LEN];
  logic [7:0] obs_data  [LOG_LEN];
  logic       obs_busy  [LOG_LEN];
  logic       obs_ferr  [LOG_LEN];
  logic       obs_ovr   [LOG_LEN];

  uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RX        (RX),
    .rd_en     (rd_en),
    .clr_err   (clr_err),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case anything ever stalls.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and log outputs 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
    if (ecnt < LOG_LEN) begin
      obs_valid[ecnt] = rx_valid;
      obs_data[ecnt]  = rx_data;
      obs_busy[ecnt]  = busy;
      obs_ferr[ecnt]  = frame_err;
      obs_ovr[ecnt]   = overrun;
    end
  endtask

  task automatic drive(input logic v, input int n);
    RX = v;
    repeat (n) tick();
  endtask

  // Drive ncyc cycles of a frame (start, 8 data LSB first, stop). Optionally
  // pulse rd_en and/or clr_err in the stop-sample (push) cycle.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input int ncyc, input logic pop_at_push,
                            input logic clr_at_push);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    ecnt = 0;
    for (int c = 0; c < ncyc; c++) begin
      RX      = bits[c / CPB];
      rd_en   = pop_at_push && (c == PUSH_EDGE - 1);
      clr_err = clr_at_push && (c == PUSH_EDGE - 1);
      tick();
    end
    rd_en   = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic pop_expect(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, rx_valid, 1'b1);
    check({tag, "_data"}, rx_data, exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic expect_empty(input string tag);
    check({tag, "_valid"}, rx_valid, 1'b0);
    check({tag, "_data"}, rx_data, 8'h00);
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic expect_reset_outputs(input string tag);
    check({tag, "_data"}, rx_data, 8'h00);
    check({tag, "_valid"}, rx_valid, 1'b0);
    check({tag, "_ferr"}, frame_err, 1'b0);
    check({tag, "_ovr"}, overrun, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    RX      = 1'b1;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    rst     = 1'b1;
    repeat (3) tick();
    expect_reset_outputs("reset");
    rst = 1'b0;
    repeat (4) tick();

    // ---- Single byte -------------------------------------------------------
    send_frame(8'hA5, 1'b1, FRAME_CYC, 1'b0, 1'b0);
    check("single_busy_e2", obs_busy[2], 1'b0);
    check("single_busy_e3", obs_busy[3], 1'b1);
    check("single_valid_e78", obs_valid[PUSH_EDGE - 1], 1'b0);
    check("single_valid_e79", obs_valid[PUSH_EDGE], 1'b1);
    check("single_data_e79", obs_data[PUSH_EDGE], 8'hA5);
    check("single_idle_at_stop", obs_busy[PUSH_EDGE], 1'b0);
    pop_expect("single_pop", 8'hA5);
    expect_empty("single_after_pop");

    // ---- Glitch rejection --------------------------------------------------
    ecnt = 0;
    drive(1'b0, 2);
    drive(1'b1, 10);
    check("glitch_busy_e3", obs_busy[3], 1'b1);
    check("glitch_busy_e7", obs_busy[7], 1'b0);
    check("glitch_valid", rx_valid, 1'b0);
    check("glitch_ferr", frame_err, 1'b0);

    // ---- Framing error, break, recovery ------------------------------------
    send_frame(8'h3C, 1'b0, FRAME_CYC, 1'b0, 1'b0);
    check("ferr_e78", obs_ferr[PUSH_EDGE - 1], 1'b0);
    check("ferr_e79", obs_ferr[PUSH_EDGE], 1'b1);
    check("ferr_busy_e79", obs_busy[PUSH_EDGE], 1'b1);
    check("ferr_valid_e79", obs_valid[PUSH_EDGE], 1'b0);
    drive(1'b0, 40);
    check("ferr_busy_break", busy, 1'b1);
    drive(1'b1, 8);
    check("ferr_busy_e122", obs_busy[122], 1'b1);
    check("ferr_busy_e123", obs_busy[123], 1'b0);
    check("ferr_fifo_empty", rx_valid, 1'b0);
    // rd_en in the push cycle with an empty FIFO: pop ignored, push kept.
    send_frame(8'h11, 1'b1, FRAME_CYC, 1'b1, 1'b0);
    check("recover_valid_e79", obs_valid[PUSH_EDGE], 1'b1);
    check("recover_data_e79", obs_data[PUSH_EDGE], 8'h11);
    check("recover_ferr_sticky", frame_err, 1'b1);
    pop_expect("recover_pop", 8'h11);
    expect_empty("recover_after_pop");
    pulse_clr();
    check("ferr_cleared", frame_err, 1'b0);

    // ---- Overrun; clr_err in the overflow cycle loses to the set -----------
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1, FRAME_CYC, 1'b0, i == 5);
      if (i == 4) check("ovr_before", overrun, 1'b0);
    end
    check("ovr_e78", obs_ovr[PUSH_EDGE - 1], 1'b0);
    check("ovr_e79", obs_ovr[PUSH_EDGE], 1'b1);
    pop_expect("ovr_pop1", 8'h01);
    pop_expect("ovr_pop2", 8'h02);
    pop_expect("ovr_pop3", 8'h03);
    pop_expect("ovr_pop4", 8'h04);
    expect_empty("ovr_drained");
    check("ovr_still_set", overrun, 1'b1);
    pulse_clr();
    check("ovr_cleared", overrun, 1'b0);

    // ---- Full FIFO with simultaneous pop and push --------------------------
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, FRAME_CYC, 1'b0, 1'b0);
    send_frame(8'h05, 1'b1, FRAME_CYC, 1'b1, 1'b0);
    check("full_pp_ovr", overrun, 1'b0);
    check("full_pp_head_e79", obs_data[PUSH_EDGE], 8'h02);
    pop_expect("full_pp_pop1", 8'h02);
    pop_expect("full_pp_pop2", 8'h03);
    pop_expect("full_pp_pop3", 8'h04);
    pop_expect("full_pp_pop4", 8'h05);
    expect_empty("full_pp_drained");

    // ---- Reset mid-frame with bytes queued and an error flagged ------------
    send_frame(8'h3C, 1'b0, FRAME_CYC, 1'b0, 1'b0);
    drive(1'b1, 8);
    send_frame(8'hAA, 1'b1, FRAME_CYC, 1'b0, 1'b0);
    send_frame(8'h55, 1'b1, FRAME_CYC, 1'b0, 1'b0);
    send_frame(8'h99, 1'b1, 35, 1'b0, 1'b0);  // now in DATA, bit index 3
    check("midrst_pre_busy", busy, 1'b1);
    check("midrst_pre_valid", rx_valid, 1'b1);
    check("midrst_pre_ferr", frame_err, 1'b1);
    RX  = 1'b1;
    rst = 1'b1;
    tick();
    expect_reset_outputs("midrst");
    rst = 1'b0;
    repeat (4) tick();
    send_frame(8'h7E, 1'b1, FRAME_CYC, 1'b0, 1'b0);
    check("post_rst_valid_e79", obs_valid[PUSH_EDGE], 1'b1);
    pop_expect("post_rst_pop", 8'h7E);
    expect_empty("post_rst_drained");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
